event_latch_bank: RTL and testbench

//  Clocked, parametrised bank of set/reset event latches. Successor to the single async RS latch.

---
 rtl/event_latch_if.sv | 22 ++
 rtl/event_latch_bank.sv | 74 +++++++
 tb/tb_event_latch_bank.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/event_latch_if.sv
// event_latch_if: trigger/clear inputs and latch/arbitration outputs of event_latch_bank
interface event_latch_if #(
    parameter int N_CH  = 2,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0]  i_trig;
    logic [N_CH-1:0]  i_clr;
    logic             i_clr_all;
    logic [N_CH-1:0]  o_q;
    logic [N_CH-1:0]  o_set_pulse;
    logic             o_any_set;
    logic             o_first_valid;
    logic [IDX_W-1:0] o_first_idx;
    modport master (
        output i_trig, i_clr, i_clr_all,
        input  o_q, o_set_pulse, o_any_set, o_first_valid, o_first_idx
    );
    modport slave (
        input  i_trig, i_clr, i_clr_all,
        output o_q, o_set_pulse, o_any_set, o_first_valid, o_first_idx
    );
endinterface

// File: rtl/event_latch_bank.sv
// event_latch_bank: bank of set/clear event latches with first-to-fire arbitration
// and optional lockout; define LATCH_SYNC_EN to add 2-flop trigger synchronisers.
module event_latch_bank #(
    parameter int N_CH    = 2,
    parameter bit EDGE    = 1'b1,
    parameter bit LOCKOUT = 1'b0
) (
    input logic         clk,
    input logic         rst,
    event_latch_if.slave bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    typedef enum logic {IDLE, CAPTURED} state_t;
    state_t           r_state, w_state_nxt;
    logic [N_CH-1:0]  w_trig, r_trig_prev, w_set_req, w_acc, w_q_nxt, r_q, r_set_pulse;
    logic [IDX_W-1:0] r_first_idx, w_idx_nxt, w_win;
    logic             w_blocked;
`ifdef LATCH_SYNC_EN
    logic [N_CH-1:0]  r_sync1, r_sync2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.i_trig;
            r_sync2 <= r_sync1;
        end
    end
    assign w_trig = r_sync2;
`else
    assign w_trig = bus.i_trig;
`endif
    assign w_blocked = LOCKOUT && (r_state == CAPTURED);
    assign w_set_req = EDGE ? (w_trig & ~r_trig_prev) : w_trig;
    // A set only counts as accepted if no clear overrides it this cycle
    assign w_acc     = w_set_req & ~bus.i_clr & ~{N_CH{bus.i_clr_all | w_blocked}};
    assign w_q_nxt   = (r_q & ~bus.i_clr & ~{N_CH{bus.i_clr_all}}) | w_acc;
    always_comb begin
        w_win = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (w_acc[i]) w_win = IDX_W'(i);
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_first_idx;
        if (bus.i_clr_all) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else if (r_state == IDLE && |w_acc) begin
            w_state_nxt = CAPTURED;
            w_idx_nxt   = w_win;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_first_idx <= '0;
            r_q         <= '0;
            r_set_pulse <= '0;
            r_trig_prev <= '1;
        end else begin
            r_state     <= w_state_nxt;
            r_first_idx <= w_idx_nxt;
            r_q         <= w_q_nxt;
            r_set_pulse <= w_q_nxt & ~r_q;
            r_trig_prev <= w_trig;
        end
    end
    assign bus.o_q           = r_q;
    assign bus.o_set_pulse   = r_set_pulse;
    assign bus.o_any_set     = |r_q;
    assign bus.o_first_valid = (r_state == CAPTURED);
    assign bus.o_first_idx   = r_first_idx;
endmodule

// File: tb/tb_event_latch_bank.sv
// tb_event_latch_bank: three configurations (edge, level, edge+lockout) driven in parallel
// and compared every cycle against a cycle-level reference model.
module tb_event_latch_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] trig = 2'b00;
    logic [1:0] clr = 2'b00;
    logic       clr_all = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    always #5 clk = ~clk;

    event_latch_if #(.N_CH(2)) if0 ();
    event_latch_if #(.N_CH(2)) if1 ();
    event_latch_if #(.N_CH(2)) if2 ();
    assign if0.i_trig = trig; assign if0.i_clr = clr; assign if0.i_clr_all = clr_all;
    assign if1.i_trig = trig; assign if1.i_clr = clr; assign if1.i_clr_all = clr_all;
    assign if2.i_trig = trig; assign if2.i_clr = clr; assign if2.i_clr_all = clr_all;
    event_latch_bank #(.N_CH(2), .EDGE(1'b1), .LOCKOUT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    event_latch_bank #(.N_CH(2), .EDGE(1'b0), .LOCKOUT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    event_latch_bank #(.N_CH(2), .EDGE(1'b1), .LOCKOUT(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [6:0] obs [3];
    assign obs[0] = {if0.o_q, if0.o_set_pulse, if0.o_any_set, if0.o_first_valid, if0.o_first_idx};
    assign obs[1] = {if1.o_q, if1.o_set_pulse, if1.o_any_set, if1.o_first_valid, if1.o_first_idx};
    assign obs[2] = {if2.o_q, if2.o_set_pulse, if2.o_any_set, if2.o_first_valid, if2.o_first_idx};

    // Reference model state per configuration
    bit         cfg_edge [3] = '{1'b1, 1'b0, 1'b1};
    bit         cfg_lock [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] m_q [3], m_sp [3], m_prev [3];
    logic       m_fv [3];
    logic       m_fi [3];
    logic [1:0] h1, h2;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 2'b00; m_sp[k] = 2'b00; m_fv[k] = 1'b0; m_fi[k] = 1'b0; m_prev[k] = 2'b11;
        end
        h1 = 2'b11; h2 = 2'b11;
    endtask

    task automatic model_step(input logic [1:0] t, input logic [1:0] c, input logic ca);
        logic [1:0] eff, old;
        int win;
        bit req;
`ifdef LATCH_SYNC_EN
        eff = h2;
`else
        eff = t;
`endif
        for (int k = 0; k < 3; k++) begin
            old = m_q[k];
            win = -1;
            for (int i = 0; i < 2; i++) begin
                req = cfg_edge[k] ? (eff[i] && !m_prev[k][i]) : eff[i];
                if (ca || c[i]) m_q[k][i] = 1'b0;
                else if (req && !(cfg_lock[k] && m_fv[k])) begin
                    m_q[k][i] = 1'b1;
                    if (win < 0) win = i;
                end
            end
            m_sp[k] = m_q[k] & ~old;
            if (ca) begin
                m_fv[k] = 1'b0; m_fi[k] = 1'b0;
            end else if (!m_fv[k] && win >= 0) begin
                m_fv[k] = 1'b1; m_fi[k] = (win == 1);
            end
            m_prev[k] = eff;
        end
        h2 = h1; h1 = t;
    endtask

    task automatic check_all(input string tag);
        logic [6:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            exp_v = {m_q[k], m_sp[k], |m_q[k], m_fv[k], m_fi[k]};
            n_cmp++;
            assert (obs[k] === exp_v) else begin
                n_bad++;
                $error("FAIL %s dut%0d observed=%b expected=%b (q,pulse,any,fv,idx)", tag, k, obs[k], exp_v);
            end
        end
    endtask

    task automatic step(input string tag, input logic [1:0] t, input logic [1:0] c, input logic ca);
        trig = t; clr = c; clr_all = ca;
        @(posedge clk);
        model_step(t, c, ca);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        // first capture and single pulse
        step("t1_fire", 2'b01, 2'b00, 1'b0);
        repeat (3) step("t1_idle", 2'b00, 2'b00, 1'b0);
        // simultaneous capture, then clear of the winner
        step("t2_clrall", 2'b00, 2'b00, 1'b1);
        step("t2_both", 2'b11, 2'b00, 1'b0);
        repeat (2) step("t2_hold", 2'b00, 2'b00, 1'b0);
        step("t2_clr0", 2'b00, 2'b01, 1'b0);
        repeat (2) step("t2_after", 2'b00, 2'b00, 1'b0);
        // long hold, with a mid-hold clear of channel 1
        step("t3_clrall", 2'b00, 2'b00, 1'b1);
        repeat (5) step("t3_hold", 2'b10, 2'b00, 1'b0);
        step("t3_clr1", 2'b10, 2'b10, 1'b0);
        repeat (5) step("t3_hold2", 2'b10, 2'b00, 1'b0);
        step("t3_rel", 2'b00, 2'b00, 1'b0);
        // lockout sequence
        step("t4_clrall", 2'b00, 2'b00, 1'b1);
        step("t4_ch1", 2'b10, 2'b00, 1'b0);
        step("t4_gap", 2'b00, 2'b00, 1'b0);
        step("t4_ch0", 2'b01, 2'b00, 1'b0);
        repeat (3) step("t4_wait", 2'b00, 2'b00, 1'b0);
        step("t4_clrall2", 2'b00, 2'b00, 1'b1);
        step("t4_ch0b", 2'b01, 2'b00, 1'b0);
        repeat (3) step("t4_end", 2'b00, 2'b00, 1'b0);
        // clear beats set
        step("t5_clrall", 2'b00, 2'b00, 1'b1);
        step("t5_clrset", 2'b01, 2'b01, 1'b0);
        repeat (3) step("t5_idle", 2'b00, 2'b00, 1'b0);
        step("t5_allset", 2'b01, 2'b00, 1'b1);
        repeat (3) step("t5_idle2", 2'b00, 2'b00, 1'b0);
        // randomized traffic
        for (int n = 0; n < 300; n++)
            step("rand", 2'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                 $urandom_range(0, 15) == 0);
        // asynchronous reset mid-capture, trigger held through release
        step("t6_pre", 2'b00, 2'b00, 1'b1);
        step("t6_fire", 2'b01, 2'b00, 1'b0);
        step("t6_fire2", 2'b00, 2'b00, 1'b0);
        step("t6_fire3", 2'b00, 2'b00, 1'b0);
        #2;
        trig = 2'b11;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("t6_inreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step("t6_held", 2'b11, 2'b00, 1'b0);
        repeat (4) step("t6_drop", 2'b00, 2'b00, 1'b0);
        step("t6_new", 2'b10, 2'b00, 1'b0);
        repeat (4) step("t6_lat", 2'b00, 2'b00, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
